// File: rtl/spike_count_decoder_if.sv
// Purpose : bundles the spike input bus and the classification result bus of the decoder.
// Ports   : spike/in_valid (upstream -> decoder); result, max_count, margin, early,
//           saturated, out_valid, busy (decoder -> consumer). master = upstream/consumer, slave = decoder.
interface spike_count_decoder_if #(
    parameter int OUTPUT_SIZE   = 10,
    parameter int OUTPUT_WIDTH  = 4,
    parameter int COUNTER_WIDTH = 8
);
    logic [OUTPUT_SIZE-1:0]   spike;
    logic                     in_valid;
    logic [OUTPUT_WIDTH-1:0]  result;
    logic [COUNTER_WIDTH-1:0] max_count;
    logic [COUNTER_WIDTH-1:0] margin;
    logic                     early;
    logic                     saturated;
    logic                     out_valid;
    logic                     busy;

    modport master (
        output spike, in_valid,
        input  result, max_count, margin, early, saturated, out_valid, busy
    );

    modport slave (
        input  spike, in_valid,
        output result, max_count, margin, early, saturated, out_valid, busy
    );
endinterface

// File: rtl/spike_count_decoder.sv
// Purpose : counts per-channel output spikes over a frame, then argmax-scans and reports the
//           winning class, its count and the margin over the runner-up.
// Latency : out_valid pulses OUTPUT_SIZE+1 edges after the edge that samples in_valid=0.
// Backpr. : none; busy is high during SCAN/DONE and any spikes/in_valid there are dropped.
// Ports   : clk, rstn (async active-low), bus (slave modport: spike/in_valid in, result bus out).
module spike_count_decoder #(
    parameter int OUTPUT_SIZE    = 10,
    parameter int OUTPUT_WIDTH   = 4,
    parameter int COUNTER_WIDTH  = 8,
    parameter int EARLY_EXIT     = 0,
    parameter int EXIT_THRESHOLD = 32
) (
    input  logic clk,
    input  logic rstn,
    spike_count_decoder_if.slave bus
);
    localparam int IW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNTER_WIDTH-1:0] THR     = COUNTER_WIDTH'(EXIT_THRESHOLD);
    localparam logic [IW-1:0]            LAST_K  = IW'(OUTPUT_SIZE - 1);

    generate
        if (OUTPUT_WIDTH < 1 || OUTPUT_WIDTH < $clog2(OUTPUT_SIZE)) begin : g_bad_width
            $error("spike_count_decoder: OUTPUT_WIDTH too small for OUTPUT_SIZE");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCAN, S_DONE} state_t;

    state_t                   state, state_nxt;
    logic [COUNTER_WIDTH-1:0] cnt     [OUTPUT_SIZE];
    logic [COUNTER_WIDTH-1:0] cnt_nxt [OUTPUT_SIZE];
    logic                     count_en, inc_at_max, hit, exit_now;
    logic                     drain, early_flag, sat_flag;
    logic [IW-1:0]            scan_k;
    logic [COUNTER_WIDTH-1:0] best, second, cur;
    logic [OUTPUT_WIDTH-1:0]  idx;

    logic [OUTPUT_WIDTH-1:0]  result_q;
    logic [COUNTER_WIDTH-1:0] max_count_q, margin_q;
    logic                     early_q, saturated_q, out_valid_q;

    // The first in_valid cycle is counted while still in IDLE, so the counters see every
    // valid cycle of the frame; a draining tail of an early-exited frame is never counted.
    assign count_en = bus.in_valid && ((state == S_IDLE && !drain) || state == S_ACCUM);

    always_comb begin
        inc_at_max = 1'b0;
        hit        = 1'b0;
        for (int i = 0; i < OUTPUT_SIZE; i++) begin
            cnt_nxt[i] = cnt[i];
            if (count_en && bus.spike[i]) begin
                if (cnt[i] == CNT_MAX) inc_at_max = 1'b1;
                else                   cnt_nxt[i] = cnt[i] + 1'b1;
            end
            if (cnt_nxt[i] >= THR) hit = 1'b1;
        end
    end

    assign exit_now = (EARLY_EXIT != 0) && hit;
    assign cur      = cnt[scan_k];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.in_valid && !drain)         state_nxt = S_ACCUM;
            S_ACCUM: if (!bus.in_valid || exit_now)      state_nxt = S_SCAN;
            S_SCAN:  if (scan_k == LAST_K)               state_nxt = S_DONE;
            S_DONE:                                      state_nxt = S_IDLE;
            default:                                     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < OUTPUT_SIZE; i++) cnt[i] <= '0;
            drain       <= 1'b0;
            early_flag  <= 1'b0;
            sat_flag    <= 1'b0;
            scan_k      <= '0;
            best        <= '0;
            second      <= '0;
            idx         <= '0;
            result_q    <= '0;
            max_count_q <= '0;
            margin_q    <= '0;
            early_q     <= 1'b0;
            saturated_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (count_en) begin
                for (int i = 0; i < OUTPUT_SIZE; i++) cnt[i] <= cnt_nxt[i];
                if (inc_at_max) sat_flag <= 1'b1;
            end
            case (state)
                S_IDLE, S_ACCUM: begin
                    scan_k <= '0;
                    best   <= '0;
                    second <= '0;
                    idx    <= '0;
                    if (state == S_IDLE && !bus.in_valid) drain <= 1'b0;
                    // A threshold hit while in_valid is still high leaves the rest of this
                    // frame to be swallowed, so it cannot masquerade as a new frame.
                    if (state == S_ACCUM && exit_now) begin
                        early_flag <= 1'b1;
                        if (bus.in_valid) drain <= 1'b1;
                    end
                end
                S_SCAN: begin
                    // Strict compares keep the lowest index on ties.
                    if (cur > best) begin
                        second <= best;
                        best   <= cur;
                        idx    <= OUTPUT_WIDTH'(scan_k);
                    end else if (cur > second) begin
                        second <= cur;
                    end
                    scan_k <= scan_k + 1'b1;
                end
                S_DONE: begin
                    result_q    <= idx;
                    max_count_q <= best;
                    margin_q    <= best - second;
                    early_q     <= early_flag;
                    saturated_q <= sat_flag;
                    out_valid_q <= 1'b1;
                    for (int i = 0; i < OUTPUT_SIZE; i++) cnt[i] <= '0;
                    early_flag  <= 1'b0;
                    sat_flag    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.result    = result_q;
    assign bus.max_count = max_count_q;
    assign bus.margin    = margin_q;
    assign bus.early     = early_q;
    assign bus.saturated = saturated_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state == S_SCAN) || (state == S_DONE);
endmodule

// File: tb/tb_spike_count_decoder.sv
// Purpose : scoreboard bench for spike_count_decoder; three instances (defaults, 4-bit
//           counters, early exit at 3) see identical frames and are checked against a model.
// Ports   : none (top-level bench).
module tb_spike_count_decoder;
    typedef struct {
        int result;
        int maxc;
        int margin;
        int early;
        int sat;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   lat_fall = 0;
    bit   lat_pend = 1'b0;
    exp_t q0[$], q1[$], q2[$];

    spike_count_decoder_if #(.OUTPUT_SIZE(10), .OUTPUT_WIDTH(4), .COUNTER_WIDTH(8)) b0();
    spike_count_decoder_if #(.OUTPUT_SIZE(10), .OUTPUT_WIDTH(4), .COUNTER_WIDTH(4)) b1();
    spike_count_decoder_if #(.OUTPUT_SIZE(10), .OUTPUT_WIDTH(4), .COUNTER_WIDTH(8)) b2();

    spike_count_decoder #(.OUTPUT_SIZE(10), .OUTPUT_WIDTH(4), .COUNTER_WIDTH(8),
        .EARLY_EXIT(0), .EXIT_THRESHOLD(32)) u0 (.clk(clk), .rstn(rstn), .bus(b0));
    spike_count_decoder #(.OUTPUT_SIZE(10), .OUTPUT_WIDTH(4), .COUNTER_WIDTH(4),
        .EARLY_EXIT(0), .EXIT_THRESHOLD(15)) u1 (.clk(clk), .rstn(rstn), .bus(b1));
    spike_count_decoder #(.OUTPUT_SIZE(10), .OUTPUT_WIDTH(4), .COUNTER_WIDTH(8),
        .EARLY_EXIT(1), .EXIT_THRESHOLD(3)) u2 (.clk(clk), .rstn(rstn), .bus(b2));

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: counts per channel over the frame (cut short at the first threshold
    // crossing when early exit is on), then plain max / first-index-of-max / max-of-rest.
    function automatic exp_t model(input logic [9:0] fr[$], input int cw, input bit ee,
                                   input int thr);
        exp_t e;
        int   cnt[10];
        int   mx, best, win, second;
        bit   h;
        mx = (1 << cw) - 1;
        e = '{default: 0};
        foreach (cnt[i]) cnt[i] = 0;
        for (int c = 0; c < fr.size(); c++) begin
            for (int i = 0; i < 10; i++)
                if (fr[c][i]) begin
                    if (cnt[i] == mx) e.sat = 1;
                    else cnt[i]++;
                end
            if (ee) begin
                h = 1'b0;
                foreach (cnt[i]) if (cnt[i] >= thr) h = 1'b1;
                if (h) begin
                    e.early = 1;
                    break;
                end
            end
        end
        best = 0;
        foreach (cnt[i]) if (cnt[i] > best) best = cnt[i];
        win = 0;
        for (int i = 9; i >= 0; i--) if (cnt[i] == best) win = i;
        second = 0;
        foreach (cnt[i]) if (i != win && cnt[i] > second) second = cnt[i];
        e.result = win;
        e.maxc   = best;
        e.margin = best - second;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [9:0] s);
        b0.in_valid = v; b1.in_valid = v; b2.in_valid = v;
        b0.spike    = s; b1.spike    = s; b2.spike    = s;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [9:0] fr[$]);
        q0.push_back(model(fr, 8, 1'b0, 32));
        q1.push_back(model(fr, 4, 1'b0, 15));
        q2.push_back(model(fr, 8, 1'b1, 3));
        foreach (fr[c]) drive(1'b1, fr[c]);
        lat_fall = cyc + 1;
        lat_pend = 1'b1;
        repeat (15) drive(1'b0, 10'd0);
    endtask

    task automatic check_out(input string tag, input exp_t e, input int r, input int m,
                             input int g, input int ea, input int sa);
        chk({tag, ".result"},    r,  e.result);
        chk({tag, ".max_count"}, m,  e.maxc);
        chk({tag, ".margin"},    g,  e.margin);
        chk({tag, ".early"},     ea, e.early);
        chk({tag, ".saturated"}, sa, e.sat);
    endtask

    task automatic unexpected(input string tag);
        n_cmp++;
        n_err++;
        $display("FAIL %s.out_valid: got 1 expected 0 (no frame pending)", tag);
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (b0.out_valid) begin
                if (q0.size() == 0) unexpected("u0");
                else begin
                    check_out("u0", q0.pop_front(), int'(b0.result), int'(b0.max_count),
                              int'(b0.margin), int'(b0.early), int'(b0.saturated));
                    if (lat_pend) begin
                        chk("u0.latency", cyc - lat_fall, 11);
                        lat_pend = 1'b0;
                    end
                end
            end
            if (b1.out_valid) begin
                if (q1.size() == 0) unexpected("u1");
                else check_out("u1", q1.pop_front(), int'(b1.result), int'(b1.max_count),
                               int'(b1.margin), int'(b1.early), int'(b1.saturated));
            end
            if (b2.out_valid) begin
                if (q2.size() == 0) unexpected("u2");
                else check_out("u2", q2.pop_front(), int'(b2.result), int'(b2.max_count),
                               int'(b2.margin), int'(b2.early), int'(b2.saturated));
            end
        end
    end

    task automatic check_cleared(input string tag);
        chk({tag, ".u0.result"},    int'(b0.result),    0);
        chk({tag, ".u0.max_count"}, int'(b0.max_count), 0);
        chk({tag, ".u0.busy"},      int'(b0.busy),      0);
        chk({tag, ".u1.max_count"}, int'(b1.max_count), 0);
        chk({tag, ".u2.max_count"}, int'(b2.max_count), 0);
        chk({tag, ".u2.early"},     int'(b2.early),     0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] fr[$];
        logic [9:0] bias;
        int         len;

        b0.in_valid = 1'b0; b1.in_valid = 1'b0; b2.in_valid = 1'b0;
        b0.spike = '0; b1.spike = '0; b2.spike = '0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        rstn = 1'b1;
        repeat (2) drive(1'b0, 10'd0);

        // ch3 x5, ch7 x3 over 5 cycles
        fr = {};
        for (int c = 0; c < 5; c++) fr.push_back(10'(1 << 3) | ((c < 3) ? 10'(1 << 7) : 10'd0));
        run_frame(fr);

        // ch2 and ch6 tie at 4, everything else 1
        fr = {10'h3FF, 10'h044, 10'h044, 10'h044};
        run_frame(fr);

        // ch1 on 20 consecutive cycles
        fr = {};
        repeat (20) fr.push_back(10'h002);
        run_frame(fr);

        // ch5 every cycle over 10 cycles
        fr = {};
        repeat (10) fr.push_back(10'h020);
        run_frame(fr);

        // empty frame
        fr = {10'h000, 10'h000, 10'h000, 10'h000};
        run_frame(fr);

        // aborted frame: reset mid-accumulation, nothing may be reported
        lat_pend = 1'b0;
        repeat (3) drive(1'b1, 10'h001);
        rstn = 1'b0;
        b0.in_valid = 1'b0; b1.in_valid = 1'b0; b2.in_valid = 1'b0;
        repeat (2) drive(1'b0, 10'd0);
        check_cleared("abort");
        rstn = 1'b1;
        repeat (2) drive(1'b0, 10'd0);
        fr = {10'h001, 10'h001, 10'h000};
        run_frame(fr);

        // randomized frames
        for (int f = 0; f < 25; f++) begin
            len  = $urandom_range(1, 24);
            bias = 10'($urandom);
            fr = {};
            for (int c = 0; c < len; c++)
                fr.push_back((10'($urandom) & bias) | (10'($urandom) & 10'($urandom) & ~bias));
            run_frame(fr);
        end

        for (int w = 0; w < 50 && (q0.size() + q1.size() + q2.size()) != 0; w++) drive(1'b0, 10'd0);
        chk("u0.pending", q0.size(), 0);
        chk("u1.pending", q1.size(), 0);
        chk("u2.pending", q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
